regbank_host: RTL and testbench
===============================

# regbank_host

Command-side controller that drives the 16x16 register bank's write_en/read_en/addr/data_in port. It accepts single read/write commands over a valid/ready interface and sequences the bank strobes. It captures read data after the bank's read latency and returns one response per command. It also provides a bulk-clear (init) sequence that zeroes every bank register. It sits between the system command source and the register bank instance.

## Interface
- ADDR_W, 4, bank address width; the bank holds 2^ADDR_W registers
- DATA_W, 16, bank data width
- READ_LAT, 1, number of clock edges after the read_en sampling edge before bank_data_out is valid; range 1..4

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  host can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target register
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_write  out  1  echo of cmd_write for this response
- rsp_rdata  out  DATA_W  read data; 0 for write responses
- init_req  in  1  request bulk clear (level or pulse)
- init_busy  out  1  clear sequence in progress
- bank_write_en  out  1  to bank write_en
- bank_read_en  out  1  to bank read_en
- bank_addr  out  ADDR_W  to bank addr
- bank_data_in  out  DATA_W  to bank data_in
- bank_data_out  in  DATA_W  from bank data_out

## Operation
- FSM states: IDLE, INIT, WR, RD, WAIT, RESP.
- IDLE:
  - If an init is pending, go to INIT; init has priority over cmd_valid.
  - Otherwise, on cmd_valid & cmd_ready, latch addr/wdata/write and go to WR or RD.
- cmd_ready is 1 only in IDLE with no init pending. The host allows one outstanding command.
- WR:
  - bank_write_en = 1 for exactly one cycle, with bank_addr = latched addr and bank_data_in = latched wdata.
  - Then go to RESP with rsp_rdata = 0.
- RD:
  - bank_read_en = 1 for exactly one cycle, with bank_addr = latched addr.
  - Then go to WAIT, which counts READ_LAT-1 further cycles.
  - Capture bank_data_out into rsp_rdata on the READ_LAT-th edge after the strobe edge, then go to RESP.
- RESP: hold rsp_valid and its payload stable until rsp_ready; on rsp_valid & rsp_ready go to IDLE.
- INIT:
  - Issue writes of 0 to addresses 0,1,…,2^ADDR_W-1, one per cycle, with bank_write_en continuously high.
  - init_busy is 1 for the whole sequence.
  - After the last address, go to IDLE.
- init_req handling:
  - init_req is latched into a pending flag whenever it is seen outside INIT.
  - A request arriving mid-command is served after that command's response handshake.
  - init_req seen during INIT is ignored; it does not retrigger.
- bank_write_en and bank_read_en are never high together.
- Outside strobe cycles, bank_addr and bank_data_in hold their last value.
- All outputs are registered.

## Timing
- Reset values: cmd_ready 0, rsp_valid 0, rsp_write 0, rsp_rdata 0, init_busy 0, bank_write_en 0, bank_read_en 0, bank_addr 0, bank_data_in 0. The FSM resets to IDLE and the pending init flag clears.
- cmd_ready rises on the first edge after rst_n deasserts.
- Write: accepting edge E0 → strobe between E0 and E1 → rsp_valid from E1.
- Read: accepting edge E0 → strobe between E0 and E1 → data captured and rsp_valid from E(1+READ_LAT). With the default READ_LAT this is E2.
- Back-to-back: with rsp_ready tied high, a new command is accepted the edge after the response handshake. Write throughput is 1 command per 3 cycles.
- Init:
  - init_busy rises on the edge leaving IDLE.
  - Writes occur over 2^ADDR_W cycles (16 by default).
  - init_busy and bank_write_en fall on the same edge that returns to IDLE.
  - cmd_ready is 0 throughout init.
- Reset mid-operation: all outputs return to reset values immediately. Any in-flight response and pending init are dropped, and bank contents are undefined.
- rsp_ready held low: the FSM stalls in RESP indefinitely, with no bank activity.

## Structure
- Package regbank_pkg:
  - FSM state enum.
  - Default ADDR_W/DATA_W constants, shared with the bank.
  - INIT_VALUE constant (0).
- Sub-module regbank_rd_delay: READ_LAT-deep valid shift register that produces the capture strobe.
- Everything else (FSM, init address counter, payload registers) stays in regbank_host.

## Test plan
- Reset, then write addr 0x0 data 0x1234, then read 0x0 → write response with rsp_rdata 0x0000, then read response rsp_rdata 0x1234 at E2 after acceptance.
- Write 0x1=0xABCD, 0x2=0x9876; read 0x2 then 0x1 → 0x9876, 0xABCD. Exactly one strobe cycle per command; strobes never overlap.
- Fill 0x0–0xF with 0xA5A0+addr, pulse init_req → init_busy high for 16 cycles with cmd_ready 0. Subsequent reads of 0x0, 0x7, 0xF return 0x0000.
- Assert init_req while a read of 0x3 sits in RESP with rsp_ready low → rsp_rdata stable. INIT starts the cycle after the handshake, and no command is accepted until init_busy falls.
- READ_LAT=3, write 0x5=0x0F0F, read 0x5 → rsp_valid at E4 after acceptance, with data 0x0F0F.
- Drop rst_n during INIT at address 0x8 → all outputs 0 immediately, init not resumed, cmd_ready 1 one edge after release.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank host controller and its bank.
package regbank_pkg;

    // Default bank geometry, shared with the register bank instance
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_READ_LAT = 1;

    // Value written to every register by the bulk-clear sequence
    localparam int INIT_VALUE = 0;

    // Host controller states
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WR,
        RD,
        WAIT,
        RESP
    } state_t;

    // Number of registers in a bank with the given address width
    function automatic int num_regs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regbank_rd_delay.sv
// Read-latency tracker: delays the bank read strobe by LAT edges so the host
// knows exactly when bank_data_out carries the requested word.
module regbank_rd_delay
    import regbank_pkg::*;
#(
    parameter int LAT = DEF_READ_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic capture
);

    logic [LAT-1:0] valid_pipe;

    // Shift the strobe through LAT stages; the oldest stage marks the capture cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= LAT'({valid_pipe, strobe});
        end
    end

    assign capture = valid_pipe[LAT-1];

endmodule

// File: rtl/regbank_host.sv
// Command-side controller for the register bank: accepts single read/write
// commands, sequences the bank strobes, returns one response per command and
// runs a bulk-clear sequence on request.
module regbank_host
    import regbank_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              init_req,
    output logic              init_busy,
    output logic              bank_write_en,
    output logic              bank_read_en,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_data_in,
    input  logic [DATA_W-1:0] bank_data_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(num_regs(ADDR_W) - 1);
    localparam logic [DATA_W-1:0] CLEAR_DATA = DATA_W'(INIT_VALUE);

    state_t state;
    logic   init_pending;
    logic   capture;
    logic   init_seen;

    // A request counts as soon as it is visible, even before it is latched
    assign init_seen = init_pending | init_req;

    regbank_rd_delay #(
        .LAT(READ_LAT)
    ) u_rd_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (bank_read_en),
        .capture(capture)
    );

    // Main controller: state, pending init flag, bank strobes and response payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            init_pending  <= 1'b0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            init_busy     <= 1'b0;
            bank_write_en <= 1'b0;
            bank_read_en  <= 1'b0;
            bank_addr     <= '0;
            bank_data_in  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_pending) begin
                        // Clear starts at address 0 with the strobe already up
                        state         <= INIT;
                        init_pending  <= 1'b0;
                        init_busy     <= 1'b1;
                        cmd_ready     <= 1'b0;
                        bank_write_en <= 1'b1;
                        bank_addr     <= '0;
                        bank_data_in  <= CLEAR_DATA;
                    end else if (cmd_valid && cmd_ready) begin
                        // A request arriving with the command waits for its response
                        cmd_ready    <= 1'b0;
                        init_pending <= init_req;
                        bank_addr    <= cmd_addr;
                        if (cmd_write) begin
                            state         <= WR;
                            bank_write_en <= 1'b1;
                            bank_data_in  <= cmd_wdata;
                        end else begin
                            state        <= RD;
                            bank_read_en <= 1'b1;
                        end
                    end else begin
                        init_pending <= init_req;
                        cmd_ready    <= !init_req;
                    end
                end

                WR: begin
                    state         <= RESP;
                    bank_write_en <= 1'b0;
                    rsp_valid     <= 1'b1;
                    rsp_write     <= 1'b1;
                    rsp_rdata     <= '0;
                    init_pending  <= init_seen;
                end

                RD: begin
                    state        <= WAIT;
                    bank_read_en <= 1'b0;
                    init_pending <= init_seen;
                end

                WAIT: begin
                    init_pending <= init_seen;
                    if (capture) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= bank_data_out;
                    end
                end

                RESP: begin
                    init_pending <= init_seen;
                    if (rsp_ready) begin
                        // Pending clear blocks new commands right from the handshake
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= !init_seen;
                    end
                end

                INIT: begin
                    if (bank_addr == LAST_ADDR) begin
                        state         <= IDLE;
                        init_busy     <= 1'b0;
                        bank_write_en <= 1'b0;
                        cmd_ready     <= 1'b1;
                    end else begin
                        bank_addr <= bank_addr + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_host.sv
// Self-checking bench for regbank_host: two hosts (read latency 1 and 3) each
// drive a behavioural bank; results are checked against a simple array model.
module tb_regbank_host;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        cmd_valid     [2];
    logic        cmd_ready     [2];
    logic        cmd_write     [2];
    logic [3:0]  cmd_addr      [2];
    logic [15:0] cmd_wdata     [2];
    logic        rsp_valid     [2];
    logic        rsp_ready     [2];
    logic        rsp_write     [2];
    logic [15:0] rsp_rdata     [2];
    logic        init_req      [2];
    logic        init_busy     [2];
    logic        bank_write_en [2];
    logic        bank_read_en  [2];
    logic [3:0]  bank_addr     [2];
    logic [15:0] bank_data_in  [2];
    logic [15:0] bank_data_out [2];

    int checkCount = 0;
    int errorCount = 0;

    // Reference contents of each bank as seen from the command side
    logic [15:0] refMem [2][16];

    // Free-running clock
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [15:0]    mem   [16];
        logic [15:0]    dpipe [LAT];
        logic [LAT-1:0] vpipe = '0;
        logic [15:0]    held  = '0;

        regbank_host #(
            .ADDR_W  (4),
            .DATA_W  (16),
            .READ_LAT(LAT)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .cmd_valid    (cmd_valid[g]),
            .cmd_ready    (cmd_ready[g]),
            .cmd_write    (cmd_write[g]),
            .cmd_addr     (cmd_addr[g]),
            .cmd_wdata    (cmd_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_write    (rsp_write[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .init_req     (init_req[g]),
            .init_busy    (init_busy[g]),
            .bank_write_en(bank_write_en[g]),
            .bank_read_en (bank_read_en[g]),
            .bank_addr    (bank_addr[g]),
            .bank_data_in (bank_data_in[g]),
            .bank_data_out(bank_data_out[g])
        );

        // Behavioural bank: data valid LAT edges after the read_en sampling edge
        always @(posedge clk) begin
            if (bank_write_en[g]) mem[bank_addr[g]] <= bank_data_in[g];
            dpipe[0] <= mem[bank_addr[g]];
            vpipe[0] <= bank_read_en[g];
            for (int i = 1; i < LAT; i++) begin
                dpipe[i] <= dpipe[i-1];
                vpipe[i] <= vpipe[i-1];
            end
            if (vpipe[LAT-1]) held <= dpipe[LAT-1];
        end

        assign bank_data_out[g] = vpipe[LAT-1] ? dpipe[LAT-1] : held;
    end

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full command: offer, accept, watch strobes, check response, handshake
    task automatic applyStimulus(input int k, input bit wr, input logic [3:0] addr,
                                 input logic [15:0] wdata, input int hold, input bit initInStall);
        logic [15:0] expData;
        logic [15:0] firstData;
        logic [3:0]  strobeAddr;
        logic [15:0] strobeData;
        logic [1:0]  strobeKind;
        int expLat, n, strobes, overlaps, stallEvents;
        bit accepted, responded;

        expData = wr ? 16'h0000 : refMem[k][addr];
        expLat  = wr ? 1 : 1 + latOf(k);
        cmd_valid[k] = 1'b1;
        cmd_write[k] = wr;
        cmd_addr[k]  = addr;
        cmd_wdata[k] = wdata;
        accepted = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready[k]) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            cmd_valid[k] = 1'b0;
            checkOutput("accept_timeout", 0, 1);
            return;
        end
        @(posedge clk);
        n = 0; strobes = 0; overlaps = 0; responded = 1'b0;
        strobeAddr = '0; strobeData = '0; strobeKind = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid[k] = 1'b0;
            if (bank_write_en[k] && bank_read_en[k]) overlaps++;
            if (bank_write_en[k] || bank_read_en[k]) begin
                strobes++;
                strobeAddr = bank_addr[k];
                strobeData = bank_data_in[k];
                strobeKind = {bank_write_en[k], bank_read_en[k]};
            end
            if (rsp_valid[k]) begin
                responded = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        checkOutput("rsp_timeout", responded, 1);
        if (!responded) return;
        checkOutput("latency", n, expLat);
        checkOutput("strobe_count", strobes, 1);
        checkOutput("strobe_overlap", overlaps, 0);
        checkOutput("strobe_kind", strobeKind, wr ? 2'b10 : 2'b01);
        checkOutput("strobe_addr", strobeAddr, addr);
        if (wr) checkOutput("strobe_data", strobeData, wdata);
        checkOutput("rsp_write", rsp_write[k], wr);
        checkOutput("rsp_rdata", rsp_rdata[k], expData);
        firstData = rsp_rdata[k];
        stallEvents = 0;
        for (int i = 0; i < hold; i++) begin
            if (initInStall) init_req[k] = (i == 0);
            @(negedge clk);
            if (!rsp_valid[k] || rsp_rdata[k] !== firstData) stallEvents++;
            if (bank_write_en[k] || bank_read_en[k]) stallEvents++;
        end
        init_req[k] = 1'b0;
        if (hold > 0) checkOutput("stall_stable", stallEvents, 0);
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        checkOutput("rsp_drop", rsp_valid[k], 0);
        if (wr) refMem[k][addr] = wdata;
    endtask

    // Follow a clear sequence from request to return to IDLE
    task automatic watchInit(input int k, input string tag);
        int pre, busy, readyDuring, seqErr;
        bit done;
        pre = 0; busy = 0; readyDuring = 0; seqErr = 0; done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (init_busy[k]) begin
                if (bank_addr[k] !== 4'(busy) || bank_data_in[k] !== 16'h0000 ||
                    !bank_write_en[k] || bank_read_en[k]) seqErr++;
                if (cmd_ready[k]) readyDuring++;
                busy++;
            end else if (busy > 0) begin
                done = 1'b1;
                break;
            end else begin
                pre++;
                if (cmd_ready[k]) readyDuring++;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_start"}, pre, 1);
        checkOutput({tag, "_len"}, busy, 16);
        checkOutput({tag, "_seq"}, seqErr, 0);
        checkOutput({tag, "_ready_low"}, readyDuring, 0);
        checkOutput({tag, "_exit"}, {bank_write_en[k], cmd_ready[k]}, 2'b01);
        if (done) begin
            for (int a = 0; a < 16; a++) refMem[k][a] = 16'h0000;
        end
    endtask

    task automatic runInit(input int k, input string tag);
        init_req[k] = 1'b1;
        @(negedge clk);
        init_req[k] = 1'b0;
        watchInit(k, tag);
    endtask

    // Hard stop in case something stalls beyond every local bound
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        bit found;
        int busyAfter;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_write[k] = 1'b0;
            cmd_addr[k]  = '0;
            cmd_wdata[k] = '0;
            rsp_ready[k] = 1'b0;
            init_req[k]  = 1'b0;
            for (int a = 0; a < 16; a++) refMem[k][a] = 16'h0000;
        end

        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {cmd_ready[0], rsp_valid[0], rsp_write[0], init_busy[0],
                                   bank_write_en[0], bank_read_en[0]}, 6'b0);
        checkOutput("reset_payload", {bank_addr[0], bank_data_in[0], rsp_rdata[0]}, 36'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", cmd_ready[0], 1);

        $display("[TB] basic write/read");
        applyStimulus(0, 1'b1, 4'h0, 16'h1234, 0, 1'b0);
        applyStimulus(0, 1'b0, 4'h0, 16'h0000, 0, 1'b0);

        $display("[TB] two writes, reversed reads with stalled responses");
        applyStimulus(0, 1'b1, 4'h1, 16'hABCD, 0, 1'b0);
        applyStimulus(0, 1'b1, 4'h2, 16'h9876, 0, 1'b0);
        applyStimulus(0, 1'b0, 4'h2, 16'h0000, 2, 1'b0);
        applyStimulus(0, 1'b0, 4'h1, 16'h0000, 2, 1'b0);

        $display("[TB] fill then bulk clear");
        for (int a = 0; a < 16; a++) applyStimulus(0, 1'b1, 4'(a), 16'hA5A0 + 16'(a), 0, 1'b0);
        runInit(0, "init_pulse");
        applyStimulus(0, 1'b0, 4'h0, 16'h0000, 0, 1'b0);
        applyStimulus(0, 1'b0, 4'h7, 16'h0000, 0, 1'b0);
        applyStimulus(0, 1'b0, 4'hF, 16'h0000, 0, 1'b0);

        $display("[TB] init requested while a read response is stalled");
        applyStimulus(0, 1'b1, 4'h3, 16'h3C3C, 0, 1'b0);
        applyStimulus(0, 1'b0, 4'h3, 16'h0000, 3, 1'b1);
        watchInit(0, "init_after_rsp");
        applyStimulus(0, 1'b0, 4'h3, 16'h0000, 0, 1'b0);

        $display("[TB] read latency 3");
        applyStimulus(1, 1'b1, 4'h5, 16'h0F0F, 0, 1'b0);
        applyStimulus(1, 1'b0, 4'h5, 16'h0000, 0, 1'b0);

        $display("[TB] randomized commands");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          16'($urandom), $urandom_range(0, 2), 1'b0);
        end

        $display("[TB] reset during clear");
        init_req[0] = 1'b1;
        @(negedge clk);
        init_req[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (init_busy[0] && bank_addr[0] == 4'h8) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("reach_addr8", found, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ctrl", {cmd_ready[0], rsp_valid[0], rsp_write[0], init_busy[0],
                                      bank_write_en[0], bank_read_en[0]}, 6'b0);
        checkOutput("midreset_payload", {bank_addr[0], bank_data_in[0], rsp_rdata[0]}, 36'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_midreset", cmd_ready[0], 1);
        busyAfter = 0;
        for (int i = 0; i < 4; i++) begin
            if (init_busy[0] || bank_write_en[0]) busyAfter++;
            @(negedge clk);
        end
        checkOutput("init_not_resumed", busyAfter, 0);
        applyStimulus(0, 1'b1, 4'h9, 16'h5555, 0, 1'b0);
        applyStimulus(0, 1'b0, 4'h9, 16'h0000, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
